// File: rtl/pwm_sink_pkg.sv
// Shared defaults and sample type for the PWM audio sink.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_sink_pkg;

    localparam int PWM_BITS_DEF = 8;  // sample width and PWM counter width
    localparam int DEPTH_DEF    = 4;  // sample FIFO entries (power of two, >= 2)

    // Unsigned audio sample as produced by the bytebeat generator.
    typedef logic [PWM_BITS_DEF-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding audio samples between generator and PWM.
// Latency: a push is visible on pop_dat/empty the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; full/empty are
// decoded from registered pointers only.
// Ports: push/push_dat write side, pop/pop_dat read side (show-ahead head),
// full/empty status flags.
module sample_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read once the pointers say so.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/pwm_sample_sink.sv
// Plays queued audio samples as a 1-bit PWM stream, one sample per PWM period.
// Latency: a sample popped at a period boundary drives pwm_out from the next
// period; pwm_out itself is registered (one cycle behind the counter).
// Backpressure: sample_in_rdy = FIFO not full, decoded from state only.
// Ports: sample_in/_vld/_rdy input stream, enable gates playback, pwm_out
// audio bit, sample_tick pulses on each duty load, underrun_count saturates.
module pwm_sample_sink
    import pwm_sink_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] sample_in,
    input  logic                sample_in_vld,
    output logic                sample_in_rdy,
    input  logic                enable,
    output logic                pwm_out,
    output logic                sample_tick,
    output logic [7:0]          underrun_count
);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                boundary;
    logic                pop;

    assign sample_in_rdy = !fifo_full;
    assign push          = sample_in_vld && sample_in_rdy;

    // Last cycle of a period. The FIFO is never bypassed: a sample arriving in
    // this very cycle is not yet visible through fifo_empty.
    assign boundary = enable && (cnt == '1);
    assign pop      = boundary && !fifo_empty;

    sample_fifo #(
        .W     (PWM_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (sample_in),
        .pop      (pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            duty           <= '0;
            pwm_out        <= 1'b0;
            sample_tick    <= 1'b0;
            underrun_count <= '0;
        end else begin
            // Counter parks at 0 while disabled so re-enable starts a fresh period.
            cnt         <= enable ? cnt + PWM_BITS'(1) : '0;
            pwm_out     <= enable && (cnt < duty);
            sample_tick <= pop;
            if (pop) begin
                duty <= fifo_head;
            end
            if (boundary && fifo_empty && (underrun_count != 8'hFF)) begin
                underrun_count <= underrun_count + 8'd1;
            end
        end
    end

endmodule
